dm_arbiter: RTL and testbench

Shared data-memory arbiter between the `NUM_C` processor cores and the external com port. It accepts one access request per requester, issues at most one DRAM access per cycle through registered memory-side signals, and returns read data with a per-requester valid pulse. The block sits between the core array / selector and the `DRAM` instance, replacing the fixed address and write-enable fan-in with arbitrated single-port access.

---
 rtl/dm_arbiter_if.sv | 38 +++
 rtl/dm_arbiter.sv | 79 +++++++
 tb/tb_dm_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester, com-port and DRAM-side signals of dm_arbiter.
interface dm_arbiter_if #(
  parameter int NUM_C = 4,
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [1:0] status;
  logic [NUM_C-1:0] core_req;
  logic [NUM_C-1:0] core_we;
  logic [NUM_C*AW-1:0] core_addr;
  logic [NUM_C*DW-1:0] core_wdata;
  logic [NUM_C-1:0] core_gnt;
  logic [NUM_C-1:0] core_rvalid;
  logic com_req;
  logic com_we;
  logic [AW-1:0] com_addr;
  logic [DW-1:0] com_wdata;
  logic com_gnt;
  logic com_rvalid;
  logic [DW-1:0] rdata;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic busy;
  modport master (
    output status, core_req, core_we, core_addr, core_wdata,
    output com_req, com_we, com_addr, com_wdata, mem_rdata,
    input core_gnt, core_rvalid, com_gnt, com_rvalid, rdata,
    input mem_we, mem_addr, mem_wdata, busy
  );
  modport slave (
    input status, core_req, core_we, core_addr, core_wdata,
    input com_req, com_we, com_addr, com_wdata, mem_rdata,
    output core_gnt, core_rvalid, com_gnt, com_rvalid, rdata,
    output mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port DRAM arbitration for NUM_C cores and the com port.
// Round-robin among cores by default; define DM_ARB_FIXED_PRIO_EN for lowest-index-wins.
module dm_arbiter #(
  parameter int NUM_C = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input logic clk,
  input logic rst,
  dm_arbiter_if.slave bus
);
  localparam int LW = NUM_C > 1 ? $clog2(NUM_C) : 1;
  logic [NUM_C-1:0] core_ok;
  logic com_ok;
  logic win_core;
  logic win;
  logic win_we;
  logic [LW-1:0] win_idx;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
`ifndef DM_ARB_FIXED_PRIO_EN
  logic [LW-1:0] last;
`endif
  // last cycle's grantee still holds its request, so it sits this cycle out
  assign core_ok = bus.status == 2'b10 ? bus.core_req & ~bus.core_gnt : '0;
  assign com_ok = bus.status[0] & bus.com_req & ~bus.com_gnt;
  always_comb begin
    int j;
    j = 0;
    win_core = 1'b0;
    win_idx = '0;
    for (int i = NUM_C; i >= 1; i--) begin
`ifdef DM_ARB_FIXED_PRIO_EN
      j = i - 1;
`else
      j = (int'(last) + i) % NUM_C;
`endif
      if (core_ok[j[LW-1:0]]) begin
        win_core = 1'b1;
        win_idx = j[LW-1:0];
      end
    end
  end
  assign win = win_core | com_ok;
  assign win_we = win_core ? bus.core_we[win_idx] : bus.com_we;
  assign win_addr = win_core ? bus.core_addr[win_idx*AW +: AW] : bus.com_addr;
  assign win_wdata = win_core ? bus.core_wdata[win_idx*DW +: DW] : bus.com_wdata;
  // read data passes straight from DRAM; busy marks a read on the port this cycle
  assign bus.rdata = (|bus.core_rvalid | bus.com_rvalid) ? bus.mem_rdata : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_gnt <= '0;
      bus.com_gnt <= 1'b0;
      bus.core_rvalid <= '0;
      bus.com_rvalid <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.busy <= 1'b0;
    end else begin
      bus.core_gnt <= win_core ? NUM_C'(1) << win_idx : '0;
      bus.com_gnt <= com_ok;
      bus.core_rvalid <= bus.core_gnt & {NUM_C{bus.busy}};
      bus.com_rvalid <= bus.com_gnt & bus.busy;
      bus.mem_we <= win & win_we;
      bus.busy <= win & ~win_we;
      if (win) begin
        bus.mem_addr <= win_addr;
        bus.mem_wdata <= win_wdata;
      end
    end
  end
`ifndef DM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= LW'(NUM_C - 1);
    else if (win_core) last <= win_idx;
  end
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus random traffic against a request-level reference model.
module tb_dm_arbiter;
  localparam int NUM_C = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] pre [256];
  logic [15:0] dram [256];
  logic [15:0] mdl [256];
  logic [NUM_C-1:0] seen_core;
  logic seen_com;
  dm_arbiter_if #(.NUM_C(NUM_C), .AW(16), .DW(16)) bus ();
  dm_arbiter #(.NUM_C(NUM_C), .AW(16), .DW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) dram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= dram[bus.mem_addr[7:0]];
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: e_* is the access decided last cycle, r_* the read due now
  int e_w = -1, r_w = -1, prev = -1, last_m = NUM_C - 1;
  logic e_we;
  logic [15:0] e_a, e_d, r_d;
  always @(negedge clk) begin
    int w, d, best;
    seen_core = bus.core_gnt;
    seen_com = bus.com_gnt;
    if (rst) begin
      check("rst_flags", {bus.core_gnt, bus.com_gnt, bus.core_rvalid, bus.com_rvalid, bus.mem_we, bus.busy}, 0);
      check("rst_data", {bus.mem_addr, bus.mem_wdata, bus.rdata}, 0);
      e_w = -1; r_w = -1; prev = -1; last_m = NUM_C - 1;
    end else begin
      check("gnt", {bus.com_gnt, bus.core_gnt}, e_w < 0 ? 64'd0 : 64'd1 << e_w);
      check("mem_we", bus.mem_we, e_w >= 0 && e_we);
      check("busy", bus.busy, e_w >= 0 && !e_we);
      if (e_w >= 0) check("mem_addr", bus.mem_addr, e_a);
      if (e_w >= 0 && e_we) check("mem_wdata", bus.mem_wdata, e_d);
      check("rvalid", {bus.com_rvalid, bus.core_rvalid}, r_w < 0 ? 64'd0 : 64'd1 << r_w);
      if (r_w >= 0) check("rdata", bus.rdata, r_d);
      r_w = -1;
      if (e_w >= 0) begin
        if (e_we) mdl[e_a[7:0]] = e_d;
        else begin
          r_w = e_w;
          r_d = mdl[e_a[7:0]];
        end
      end
      w = -1;
      best = NUM_C + 1;
      if (bus.status == 2'b10) begin
        for (int c = 0; c < NUM_C; c++) if (bus.core_req[c] && c != prev) begin
`ifdef DM_ARB_FIXED_PRIO_EN
          d = c;
`else
          d = (c - last_m - 1 + 2 * NUM_C) % NUM_C;
`endif
          if (d < best) begin
            best = d;
            w = c;
          end
        end
      end else if (bus.status != 2'b00 && bus.com_req && prev != NUM_C) w = NUM_C;
      e_w = w;
      prev = w;
      if (w == NUM_C) begin
        e_we = bus.com_we; e_a = bus.com_addr; e_d = bus.com_wdata;
      end else if (w >= 0) begin
        e_we = bus.core_we[w]; e_a = bus.core_addr[w*16 +: 16]; e_d = bus.core_wdata[w*16 +: 16];
        last_m = w;
      end
    end
  end
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic set_core(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.core_we[i] = we;
    bus.core_addr[i*16 +: 16] = a;
    bus.core_wdata[i*16 +: 16] = d;
  endtask
  task automatic com_xfer(input logic we, input logic [15:0] a, input logic [15:0] d, output bit got);
    bus.com_req = 1'b1; bus.com_we = we; bus.com_addr = a; bus.com_wdata = d;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      check("com_mode_core_gnt", bus.core_gnt, 0);
      if (bus.com_gnt) got = 1;
    end
    @(posedge clk); #1;
    bus.com_req = 1'b0;
  endtask
  initial begin
    bit got;
    int cnt;
    for (int i = 0; i < 256; i++) begin
      pre[i] = 16'($urandom);
      mdl[i] = pre[i];
      dram[i] <= pre[i];
    end
    bus.mem_rdata <= '0;
    bus.status = 2'b00; bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.com_req = 1'b0; bus.com_we = 1'b0; bus.com_addr = '0; bus.com_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // all cores reading: round-robin from core 0
    bus.status = 2'b10;
    for (int i = 0; i < NUM_C; i++) set_core(i, 1'b0, 16'h20 + 16'(i), 16'h0);
    bus.core_req = 4'hF;
    @(negedge clk);
    check("rr_first_gnt", bus.core_gnt, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_gnt", bus.core_gnt, 4'b1 << (k % 4));
      check("rr_rvalid", bus.core_rvalid, k == 0 ? 4'b0 : 4'b1 << ((k - 1) % 4));
      if (k > 0) check("rr_rdata", bus.rdata, pre[8'h20 + 8'((k - 1) % 4)]);
    end
    @(posedge clk); #1;
    bus.core_req = '0;
    repeat (3) @(posedge clk);
    #1;
    // com write in LOAD, read back in DUMP, cores ignored throughout
    bus.status = 2'b01;
    bus.core_req = 4'hF;
    com_xfer(1'b1, 16'h0010, 16'hBEEF, got);
    check("load_gnt", got, 1);
    bus.status = 2'b11;
    com_xfer(1'b0, 16'h0010, 16'h0, got);
    check("dump_gnt", got, 1);
    got = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      check("dump_core_gnt", bus.core_gnt, 0);
      if (bus.com_rvalid) begin
        got = 1;
        check("dump_rdata", bus.rdata, 16'hBEEF);
      end
    end
    check("dump_rvalid", got, 1);
    bus.core_req = '0;
    // lone requester: one grant every other cycle
    do_reset();
    bus.status = 2'b10;
    bus.core_req = 4'b0100;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("solo_gnt", bus.core_gnt, k % 2 == 1 ? 4'b0100 : 4'b0000);
      cnt += int'(bus.core_gnt[2]);
    end
    check("solo_count", cnt, 3);
    @(posedge clk); #1;
    bus.core_req = '0;
    @(negedge clk);
    check("solo_after", bus.core_gnt, 0);
    // reset while a read is in flight
    do_reset();
    bus.status = 2'b10;
    bus.core_req = 4'b0010;
    @(posedge clk); #1;
    check("pre_rst_gnt", bus.core_gnt, 4'b0010);
    rst = 1'b1;
    bus.core_req = '0;
    @(negedge clk);
    check("mid_rst_out", {bus.core_gnt, bus.core_rvalid, bus.mem_we, bus.busy, bus.mem_addr, bus.rdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rvalid", bus.core_rvalid, 0);
    end
    @(posedge clk); #1;
    bus.core_req = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_first", bus.core_gnt, 4'b0001);
    @(posedge clk); #1;
    bus.core_req = '0;
    // RUN -> IDLE after a core 3 read grant
    do_reset();
    bus.status = 2'b10;
    set_core(3, 1'b0, 16'h33, 16'h0);
    bus.core_req = 4'b1000;
    @(posedge clk); #1;
    bus.status = 2'b00;
    bus.core_req = 4'b1001;
    @(negedge clk);
    check("idle_gnt3", bus.core_gnt, 4'b1000);
    @(negedge clk);
    check("idle_rvalid3", bus.core_rvalid, 4'b1000);
    check("idle_rdata3", bus.rdata, pre[8'h33]);
    repeat (4) begin
      @(negedge clk);
      check("idle_no_gnt", bus.core_gnt, 0);
    end
    bus.core_req = '0;
    // cores 1 and 3 contending
    do_reset();
    bus.status = 2'b10;
    bus.core_req = 4'b1010;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("pair_gnt", bus.core_gnt, k % 2 == 0 ? 4'b0010 : 4'b1000);
    end
    @(posedge clk); #1;
    bus.core_req = '0;
    // random traffic: requesters change only after seeing their grant
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(posedge clk); #1;
      if (n % 37 == 0) begin
        r = $urandom_range(0, 7);
        bus.status = r < 4 ? 2'b10 : r == 4 ? 2'b01 : r == 5 ? 2'b11 : 2'b00;
      end
      if (n == 1500) rst = 1'b1;
      if (n == 1502) rst = 1'b0;
      for (int i = 0; i < NUM_C; i++) if (!bus.core_req[i] || seen_core[i]) begin
        bus.core_req[i] = $urandom_range(0, 3) != 0;
        set_core(i, 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom));
      end
      if (!bus.com_req || seen_com) begin
        bus.com_req = $urandom_range(0, 3) != 0;
        bus.com_we = 1'($urandom);
        bus.com_addr = 16'($urandom_range(0, 63));
        bus.com_wdata = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.core_req = '0;
    bus.com_req = 1'b0;
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
